// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: cause codes,
// FSM state encoding and the priority-encoder result record.
package trap_ctrl_pkg;

  localparam logic [3:0] CAUSE_INST_MISALIGN  = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT     = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ECALL_M        = 4'd11;
  localparam logic [3:0] CAUSE_IRQ_MSI        = 4'd3;
  localparam logic [3:0] CAUSE_IRQ_MTI        = 4'd7;
  localparam logic [3:0] CAUSE_IRQ_MEI        = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURE  = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_RET      = 2'd3
  } state_e;

  typedef struct packed {
    logic       valid;
    logic       i_or_e;
    logic [3:0] cause;
  } trap_sel_t;

endpackage

// File: rtl/trap_ctrl_prio_enc.sv
// Combinational priority encoder: exceptions always beat interrupts, and
// each group resolves by its fixed architectural order.
module trap_prio_enc
  import trap_ctrl_pkg::*;
(
  input  logic       exc_inst_misalign,
  input  logic       exc_illegal,
  input  logic       exc_ebreak,
  input  logic       exc_load_misalign,
  input  logic       exc_store_misalign,
  input  logic       exc_ecall,
  input  logic [2:0] irq_pending,  // {ext, timer, sw}, already enable/MIE gated
  output trap_sel_t  sel
);

  // NOTE: sel gets a full default before the priority chain, so every path
  // assigns it and no latch is inferred.
  always_comb begin
    sel = '0;
    if      (exc_ebreak)         sel = '{1'b1, 1'b0, CAUSE_BREAKPOINT};
    else if (exc_inst_misalign)  sel = '{1'b1, 1'b0, CAUSE_INST_MISALIGN};
    else if (exc_illegal)        sel = '{1'b1, 1'b0, CAUSE_ILLEGAL};
    else if (exc_ecall)          sel = '{1'b1, 1'b0, CAUSE_ECALL_M};
    else if (exc_store_misalign) sel = '{1'b1, 1'b0, CAUSE_STORE_MISALIGN};
    else if (exc_load_misalign)  sel = '{1'b1, 1'b0, CAUSE_LOAD_MISALIGN};
    else if (irq_pending[2])     sel = '{1'b1, 1'b1, CAUSE_IRQ_MEI};
    else if (irq_pending[0])     sel = '{1'b1, 1'b1, CAUSE_IRQ_MSI};
    else if (irq_pending[1])     sel = '{1'b1, 1'b1, CAUSE_IRQ_MTI};
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: picks the winning trap or MRET in IDLE, then
// drives the CSR capture strobes, the MIE stack pulses and the PC redirect.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int MTVEC_W = 32,
  parameter int PC_HI_W = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exc_inst_misalign,
  input  logic               exc_illegal,
  input  logic               exc_ebreak,
  input  logic               exc_load_misalign,
  input  logic               exc_store_misalign,
  input  logic               exc_ecall,
  input  logic               irq_sw,
  input  logic               irq_timer,
  input  logic               irq_ext,
  input  logic               mie_bit,
  input  logic [2:0]         irq_en,
  input  logic               is_mret,
  input  logic [PC_HI_W-1:0] inst_pc_hi,
  input  logic [MTVEC_W-1:0] mtvec_in,
  input  logic [MTVEC_W-1:0] epc_in,
  output logic               cause_set,
  output logic [3:0]         cause_code,
  output logic               i_or_e,
  output logic               mepc_set,
  output logic [PC_HI_W-1:0] epc_addr_hi,
  output logic               mie_clear,
  output logic               mie_restore,
  output logic               pc_redirect,
  output logic [MTVEC_W-1:0] redirect_pc,
  output logic               flush,
  output logic               stall,
  output logic               busy
);

  state_e     state, state_next;
  trap_sel_t  sel;
  logic [2:0] irq_pending;
  logic       unused_low_bits;

  assign irq_pending     = {irq_ext, irq_timer, irq_sw} & irq_en & {3{mie_bit}};
  assign unused_low_bits = ^{mtvec_in[1:0], epc_in[1:0]};

  trap_prio_enc u_prio (
    .exc_inst_misalign (exc_inst_misalign),
    .exc_illegal       (exc_illegal),
    .exc_ebreak        (exc_ebreak),
    .exc_load_misalign (exc_load_misalign),
    .exc_store_misalign(exc_store_misalign),
    .exc_ecall         (exc_ecall),
    .irq_pending       (irq_pending),
    .sel               (sel)
  );

  // NOTE: nonblocking assignments so state and the captured trap record all
  // update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cause_code  <= '0;
      i_or_e      <= 1'b0;
      epc_addr_hi <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && sel.valid) begin
        cause_code  <= sel.cause;
        i_or_e      <= sel.i_or_e;
        epc_addr_hi <= inst_pc_hi;
      end
    end
  end

  always_comb begin
    state_next  = state;
    cause_set   = 1'b0;
    mepc_set    = 1'b0;
    mie_clear   = 1'b0;
    mie_restore = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = '0;
    flush       = 1'b0;
    stall       = 1'b0;
    busy        = (state != ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        // Traps outrank MRET; the pipeline is frozen from the detection cycle.
        if (sel.valid) begin
          state_next = ST_CAPTURE;
          flush      = 1'b1;
          stall      = 1'b1;
        end else if (is_mret) begin
          state_next = ST_RET;
        end
      end
      ST_CAPTURE: begin
        cause_set  = 1'b1;
        mepc_set   = 1'b1;
        mie_clear  = 1'b1;
        flush      = 1'b1;
        stall      = 1'b1;
        state_next = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        pc_redirect = 1'b1;
        redirect_pc = {mtvec_in[MTVEC_W-1:2], 2'b00};
        flush       = 1'b1;
        stall       = 1'b1;
        state_next  = ST_IDLE;
      end
      ST_RET: begin
        pc_redirect = 1'b1;
        redirect_pc = {epc_in[MTVEC_W-1:2], 2'b00};
        mie_restore = 1'b1;
        flush       = 1'b1;
        stall       = 1'b1;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // Reset suppresses every combinational strobe immediately.
    if (rst) begin
      cause_set   = 1'b0;
      mepc_set    = 1'b0;
      mie_clear   = 1'b0;
      mie_restore = 1'b0;
      pc_redirect = 1'b0;
      redirect_pc = '0;
      flush       = 1'b0;
      stall       = 1'b0;
      busy        = 1'b0;
    end
  end

endmodule
